// File: rtl/sprite_pkg.sv
// Shared constants, config record and ROM base-offset helper for the sprite scheduler.
package sprite_pkg;
    localparam int NUM_SPRITES  = 4;
    localparam int WIDTH        = 110;
    localparam int HEIGHT       = 59;
    localparam int SPRITE_WORDS = WIDTH * HEIGHT;
    localparam int ADDR_W       = 15;
    localparam int ROM_LAT      = 2;
    localparam int ID_W         = $clog2(NUM_SPRITES);
    localparam int OFF_W        = 13;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        en;
    } sprite_cfg_t;

    // Sprites are stacked back to back in the ROM; index is a loop constant so this folds away.
    function automatic logic [ADDR_W-1:0] base_offset(input int idx);
        return ADDR_W'(idx * SPRITE_WORDS);
    endfunction
endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite rectangle hit test and local ROM offset for the current raster position.
module sprite_hit_unit
    import sprite_pkg::*;
(
    input  sprite_cfg_t       cfg,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic              hit,
    output logic [OFF_W-1:0]  offset
);
    // One extra bit on the far edges so sprites near the raster end clip instead of wrapping.
    logic [11:0] x_end;
    logic [10:0] y_end;
    logic [10:0] dx;
    logic [9:0]  dy;

    assign x_end  = {1'b0, cfg.x} + 12'(WIDTH);
    assign y_end  = {1'b0, cfg.y} + 11'(HEIGHT);
    assign dx     = hcount - cfg.x;
    assign dy     = vcount - cfg.y;
    assign hit    = cfg.en && (hcount >= cfg.x) && ({1'b0, hcount} < x_end)
                           && (vcount >= cfg.y) && ({1'b0, vcount} < y_end);
    assign offset = OFF_W'(dx) + OFF_W'(dy) * OFF_W'(WIDTH);
endmodule

// File: rtl/sprite_scheduler.sv
// Picks the highest-priority sprite under the raster, drives the shared ROM address and
// composites the returned colour after the ROM/colour-map latency.
module sprite_scheduler
    import sprite_pkg::*;
(
    input  logic                   pixel_clk,
    input  logic                   reset_n,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ID_W-1:0]        cfg_id,
    input  logic [10:0]            cfg_x,
    input  logic [9:0]             cfg_y,
    input  logic                   cfg_en,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [23:0]            color_in,
    output logic [23:0]            pixel,
    output logic [ID_W-1:0]        pixel_id,
    output logic [NUM_SPRITES-1:0] overlap_mask
);
    sprite_cfg_t [NUM_SPRITES-1:0]            shadow_q, active_q;
    logic        [NUM_SPRITES-1:0]            hits;
    logic        [NUM_SPRITES-1:0][OFF_W-1:0] offs;
    logic        [NUM_SPRITES-1:0]            ovl_acc;
    logic        [ROM_LAT:0]                  hit_pipe;
    logic        [ROM_LAT:0][ID_W-1:0]        id_pipe;
    logic                                     commit, cfg_fire, hit_any, multi_hit;
    logic        [ID_W-1:0]                   win_id;
    logic        [ADDR_W-1:0]                 win_addr;

    assign commit    = (hcount == 11'd0) && (vcount == 10'd0);
    assign cfg_ready = !commit || !reset_n;
    assign cfg_fire  = cfg_valid && !commit;

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (cfg_fire)
                shadow_q[cfg_id] <= '{x: cfg_x, y: cfg_y, en: cfg_en};
            if (commit)
                active_q <= shadow_q;
        end
    end

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
        sprite_hit_unit u_hit (
            .cfg    (active_q[i]),
            .hcount (hcount),
            .vcount (vcount),
            .hit    (hits[i]),
            .offset (offs[i])
        );
    end

    // Scan from lowest priority up so the lowest hitting index overwrites last.
    always_comb begin
        hit_any  = 1'b0;
        win_id   = '0;
        win_addr = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_any  = 1'b1;
                win_id   = ID_W'(i);
                win_addr = base_offset(i) + ADDR_W'(offs[i]);
            end
        end
    end

    assign multi_hit = |(hits & (hits - NUM_SPRITES'(1)));

    // hit_pipe[0] is stage A; hit_pipe[ROM_LAT] lines up with color_in.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr     <= '0;
            hit_pipe     <= '0;
            id_pipe      <= '0;
            pixel        <= '0;
            pixel_id     <= '0;
            overlap_mask <= '0;
            ovl_acc      <= '0;
        end else begin
            if (hit_any)
                rom_addr <= win_addr;
            hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit_any};
            id_pipe  <= {id_pipe[ROM_LAT-1:0], win_id};
            pixel    <= hit_pipe[ROM_LAT] ? color_in : 24'd0;
            pixel_id <= hit_pipe[ROM_LAT] ? id_pipe[ROM_LAT] : '0;
            if (commit) begin
                overlap_mask <= ovl_acc;
                ovl_acc      <= '0;
            end else if (multi_hit) begin
                ovl_acc <= ovl_acc | hits;
            end
        end
    end
endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a two-cycle ROM + colour-map model on color_in.
module tb_sprite_scheduler;
    import sprite_pkg::*;

    logic                   pixel_clk = 1'b0;
    logic                   reset_n   = 1'b0;
    logic [10:0]            hcount    = 11'd5;
    logic [9:0]             vcount    = 10'd5;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [ID_W-1:0]        cfg_id    = '0;
    logic [10:0]            cfg_x     = '0;
    logic [9:0]             cfg_y     = '0;
    logic                   cfg_en    = 1'b0;
    logic [ADDR_W-1:0]      rom_addr;
    logic [23:0]            color_in  = '0;
    logic [23:0]            pixel;
    logic [ID_W-1:0]        pixel_id;
    logic [NUM_SPRITES-1:0] overlap_mask;
    logic [ADDR_W-1:0]      rom_r1    = '0;
    int checks = 0;
    int errors = 0;

    sprite_scheduler dut (
        .pixel_clk    (pixel_clk),
        .reset_n      (reset_n),
        .hcount       (hcount),
        .vcount       (vcount),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_id       (cfg_id),
        .cfg_x        (cfg_x),
        .cfg_y        (cfg_y),
        .cfg_en       (cfg_en),
        .rom_addr     (rom_addr),
        .color_in     (color_in),
        .pixel        (pixel),
        .pixel_id     (pixel_id),
        .overlap_mask (overlap_mask)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [23:0] rom_color(input logic [ADDR_W-1:0] a);
        return {8'hA5, 1'b0, a};
    endfunction

    // ROM (1 cycle) followed by colour map (1 cycle).
    always @(posedge pixel_clk) begin
        rom_r1   <= rom_addr;
        color_in <= rom_color(rom_r1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic go(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic cfg_wr(input int id, input int x, input int y, input logic en);
        cfg_valid = 1'b1;
        cfg_id    = ID_W'(id);
        cfg_x     = 11'(x);
        cfg_y     = 10'(y);
        cfg_en    = en;
        go(500, 100);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("rst_pixel", pixel, 0);
        chk("rst_id", pixel_id, 0);
        chk("rst_ovl", overlap_mask, 0);
        chk("rst_rom", rom_addr, 0);
        chk("rst_ready", cfg_ready, 1);
        #2 reset_n = 1'b1;

        // Unconfigured raster: nothing drawn
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 200; h++) begin
                go(h, v);
                chk("blank_pixel", pixel, 0);
                chk("blank_id", pixel_id, 0);
                chk("blank_ovl", overlap_mask, 0);
            end

        // Sprite 1 configured mid-frame is not visible until commit
        go(300, 20);
        cfg_valid = 1'b1;
        cfg_id = 2'd1; cfg_x = 11'd100; cfg_y = 10'd50; cfg_en = 1'b1;
        #1 chk("cfg_ready_mid", cfg_ready, 1);
        go(300, 20);
        cfg_valid = 1'b0;
        go(100, 50);
        chk("precommit_rom", rom_addr, 0);
        go(0, 0);
        go(99, 50);
        go(100, 50);  chk("s1_rom0", rom_addr, 6490);
        go(101, 50);  chk("s1_rom1", rom_addr, 6491);
        go(210, 50);  chk("s1_rom_hold", rom_addr, 6491);
                      chk("s1_lat_pix", pixel, 0);
        go(211, 50);  chk("s1_pix0", pixel, rom_color(15'd6490));
                      chk("s1_id0", pixel_id, 1);
        go(212, 50);  chk("s1_pix1", pixel, rom_color(15'd6491));
        go(213, 50);  chk("s1_edge_pix", pixel, 0);
                      chk("s1_edge_id", pixel_id, 0);

        // Overlapping sprites 0 and 2; sprite 2 written twice, last write wins
        cfg_wr(1, 100, 50, 1'b0);
        cfg_wr(0, 100, 50, 1'b1);
        cfg_wr(2, 700, 60, 1'b1);
        cfg_wr(2, 150, 60, 1'b1);
        go(0, 0);     chk("ovl_mask_none", overlap_mask, 0);
        go(160, 70);  chk("ovl_rom", rom_addr, 2260);
        go(161, 70);
        go(162, 70);
        go(163, 70);  chk("ovl_id", pixel_id, 0);
                      chk("ovl_pix", pixel, rom_color(15'd2260));
        go(0, 0);     chk("ovl_mask", overlap_mask, 4'b0101);

        // Sprite 3 at x=1000: 12-bit right edge, no wrap at column 0
        cfg_wr(3, 1000, 200, 1'b1);
        go(0, 0);
        go(999, 200);
        go(1000, 200); chk("s3_left", rom_addr, 19470);
        go(1109, 200); chk("s3_right", rom_addr, 19579);
        go(1110, 200); chk("s3_past", rom_addr, 19579);
        go(1111, 200); chk("s3_id_left", pixel_id, 3);
                       chk("s3_pix_left", pixel, rom_color(15'd19470));
        go(1112, 200); chk("s3_id_right", pixel_id, 3);
        go(1113, 200); chk("s3_id_past", pixel_id, 0);
        for (int h = 0; h < 90; h++) begin
            go(h, 200);
            chk("s3_nowrap_rom", rom_addr, 19579);
            chk("s3_nowrap_id", pixel_id, 0);
        end

        // Sprite clipped at the raster corner
        cfg_wr(3, 1990, 1000, 1'b1);
        go(0, 0);
        go(2047, 1023); chk("clip_rom", rom_addr, 22057);
        go(5, 5);       chk("clip_nowrap", rom_addr, 22057);

        // cfg_valid held across the commit cycle
        hcount = 11'd0; vcount = 10'd0;
        cfg_valid = 1'b1;
        cfg_id = 2'd1; cfg_x = 11'd300; cfg_y = 10'd300; cfg_en = 1'b1;
        #1 chk("ready_commit", cfg_ready, 0);
        @(posedge pixel_clk); #1;
        hcount = 11'd1;
        #1 chk("ready_after", cfg_ready, 1);
        @(posedge pixel_clk); #1;
        cfg_valid = 1'b0;
        go(300, 300);  chk("held_precommit", rom_addr, 22057);
        go(0, 0);
        go(300, 300);  chk("held_commit", rom_addr, 6490);

        // Asynchronous reset mid-line with sprites active
        go(160, 70);
        go(0, 0);      chk("pre_rst_mask", overlap_mask, 4'b0101);
        go(300, 300);
        go(301, 300);
        go(302, 300);
        go(303, 300);  chk("pre_rst_id", pixel_id, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pixel", pixel, 0);
        chk("arst_id", pixel_id, 0);
        chk("arst_rom", rom_addr, 0);
        chk("arst_ovl", overlap_mask, 0);
        @(posedge pixel_clk);
        #3 reset_n = 1'b1;
        go(0, 0);
        go(300, 300);
        go(301, 300);
        go(302, 300);
        go(303, 300);
        chk("post_rst_pix", pixel, 0);
        chk("post_rst_id", pixel_id, 0);
        chk("post_rst_rom", rom_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
